// File: rtl/fxp_poly_horner_if.sv
// Handshake and coefficient bus for the Horner polynomial evaluator.
// Widths are passed in so both ends agree on sample and result formats.
interface fxp_poly_horner_if #(
  parameter int WX = 16,
  parameter int WC = 16,
  parameter int WY = 24,
  parameter int AW = 2
);
  logic                 EN;
  logic                 COEF_WE;
  logic [AW-1:0]        COEF_ADDR;
  logic signed [WC-1:0] COEF_DATA;
  logic                 IN_VALID;
  logic                 IN_READY;
  logic signed [WX-1:0] X;
  logic                 OUT_VALID;
  logic                 OUT_READY;
  logic signed [WY-1:0] Y;
  logic                 OVF;
  logic                 BUSY;

  modport master (
    output EN, COEF_WE, COEF_ADDR, COEF_DATA,
    output IN_VALID, X, OUT_READY,
    input  IN_READY, OUT_VALID, Y, OVF, BUSY
  );

  modport slave (
    input  EN, COEF_WE, COEF_ADDR, COEF_DATA,
    input  IN_VALID, X, OUT_READY,
    output IN_READY, OUT_VALID, Y, OVF, BUSY
  );
endinterface

// File: rtl/fxp_poly_horner.sv
// Iterative signed fixed-point polynomial evaluator (Horner's method).
// One multiply-add per cycle, programmable coefficient bank.
module fxp_poly_horner #(
  parameter int WI_in  = 8,
  parameter int WF_in  = 8,
  parameter int WI_c   = 8,
  parameter int WF_c   = 8,
  parameter int WI_out = 16,
  parameter int WF_out = 8,
  parameter int ORDER  = 2,
  parameter int ROUND  = 1,
  parameter int SAT    = 1
) (
  input logic CLK,
  input logic RST,
  fxp_poly_horner_if.slave bus
);
  localparam int WX  = WI_in + WF_in;
  localparam int WC  = WI_c + WF_c;
  localparam int WY  = WI_out + WF_out;
  localparam int PW  = WY + WX;
  localparam int SW  = PW + 2;
  localparam int CSH = WF_out + WF_in - WF_c;
  localparam int AW  = (ORDER > 0) ? $clog2(ORDER + 1) : 1;
  localparam int RS  = (WF_in > 0) ? WF_in - 1 : 0;

  localparam logic [AW-1:0] KTOP   = AW'(ORDER);
  localparam logic [AW-1:0] KSTART = AW'((ORDER > 0) ? ORDER - 1 : 0);

  // half an output LSB in the product format, zero when truncating
  localparam logic signed [SW-1:0] RND =
    (ROUND != 0 && WF_in > 0) ? (SW'(1) << RS) : '0;

  localparam logic signed [WY-1:0] YMAX = {1'b0, {(WY-1){1'b1}}};
  localparam logic signed [WY-1:0] YMIN = {1'b1, {(WY-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t state, state_n;

  logic signed [WC-1:0] coef [ORDER+1];
  logic signed [WX-1:0] x_reg;
  logic signed [WY-1:0] acc;
  logic [AW-1:0]        k;
  logic                 ovf_r;

  logic                 accept, load, step;
  logic signed [WC-1:0] csel;
  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] addend, sum, rnd_sum, shifted;
  logic [SW-WY:0]       hi;
  logic signed [WY-1:0] rq;
  logic                 rq_ovf;

  assign bus.IN_READY  = bus.EN &
    ((state == IDLE) | ((state == HOLD) & bus.OUT_READY));
  assign accept        = bus.IN_VALID & bus.IN_READY;
  assign bus.OUT_VALID = (state == HOLD);
  assign bus.BUSY      = (state == CALC);
  assign bus.Y         = acc;
  assign bus.OVF       = ovf_r;

  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // next state plus load/step strobes for the datapath
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          load    = 1'b1;
          state_n = (ORDER == 0) ? HOLD : CALC;
        end
      end
      CALC: begin
        if (bus.EN) begin
          step = 1'b1;
          if (k == '0) state_n = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          load    = 1'b1;
          state_n = (ORDER == 0) ? HOLD : CALC;
        end else if (bus.EN & bus.OUT_READY) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // multiply-add in the wide product format, then round/shift/clamp
  always_comb begin
    csel    = (state == CALC) ? coef[k] : coef[ORDER];
    prod    = PW'(acc) * PW'(x_reg);
    addend  = {{(SW-WC){csel[WC-1]}}, csel} << CSH;
    sum     = (state == CALC) ?
              {{2{prod[PW-1]}}, prod} + addend : addend;
    rnd_sum = sum + RND;
    shifted = rnd_sum >>> WF_in;
    hi      = shifted[SW-1:WY-1];
    rq_ovf  = ~(&hi | ~|hi);
    rq      = shifted[WY-1:0];
    if (rq_ovf && SAT != 0) rq = shifted[SW-1] ? YMIN : YMAX;
  end

  // accumulator, sample latch, iteration counter and sticky overflow
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc   <= '0;
      x_reg <= '0;
      k     <= '0;
      ovf_r <= 1'b0;
    end else if (load) begin
      x_reg <= bus.X;
      acc   <= rq;
      ovf_r <= rq_ovf;
      k     <= KSTART;
    end else if (step) begin
      acc   <= rq;
      ovf_r <= ovf_r | rq_ovf;
      k     <= k - 1'b1;
    end
  end

  // coefficient bank, writable only while no evaluation is running
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i <= ORDER; i++) coef[i] <= '0;
    end else if (bus.EN & bus.COEF_WE & (state != CALC) &
                 (bus.COEF_ADDR <= KTOP)) begin
      coef[bus.COEF_ADDR] <= bus.COEF_DATA;
    end
  end
endmodule

// File: tb/tb_fxp_poly_horner.sv
// Bench for fxp_poly_horner: a rounding/saturating and a flooring/wrapping
// instance share one stimulus stream; results checked through a scoreboard.
module tb_fxp_poly_horner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en, coef_we, in_valid, out_ready;
  logic [1:0]  coef_addr;
  logic [15:0] coef_data, x;

  int tests = 0;
  int fails = 0;

  fxp_poly_horner_if #(.WX(16), .WC(16), .WY(24), .AW(2)) bus_a ();
  fxp_poly_horner_if #(.WX(16), .WC(16), .WY(24), .AW(2)) bus_b ();

  assign bus_a.EN        = en;
  assign bus_a.COEF_WE   = coef_we;
  assign bus_a.COEF_ADDR = coef_addr;
  assign bus_a.COEF_DATA = coef_data;
  assign bus_a.IN_VALID  = in_valid;
  assign bus_a.X         = x;
  assign bus_a.OUT_READY = out_ready;
  assign bus_b.EN        = en;
  assign bus_b.COEF_WE   = coef_we;
  assign bus_b.COEF_ADDR = coef_addr;
  assign bus_b.COEF_DATA = coef_data;
  assign bus_b.IN_VALID  = in_valid;
  assign bus_b.X         = x;
  assign bus_b.OUT_READY = out_ready;

  fxp_poly_horner #(.ROUND(1), .SAT(1)) dut_a (
    .CLK(clk), .RST(rst), .bus(bus_a)
  );
  fxp_poly_horner #(.ROUND(0), .SAT(0)) dut_b (
    .CLK(clk), .RST(rst), .bus(bus_b)
  );

  typedef struct {
    logic [23:0] y;
    logic        o;
  } exp_t;

  typedef struct {
    logic [15:0] c2, c1, c0, x;
    logic [23:0] ya;
    logic        oa;
    logic [23:0] yb;
    logic        ob;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  vec_t vt[9];

  task automatic check(string nm, logic [23:0] act, logic [23:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // pop and compare whenever a result is handed downstream
  always @(negedge clk) begin
    exp_t e;
    if (!rst && en && out_ready) begin
      if (bus_a.OUT_VALID) begin
        if (qa.size() == 0) begin
          tests++; fails++;
          $display("FAIL a_extra: got %h want none", bus_a.Y);
        end else begin
          e = qa.pop_front();
          check("a_y", bus_a.Y, e.y);
          check("a_ovf", bus_a.OVF, e.o);
        end
      end
      if (bus_b.OUT_VALID) begin
        if (qb.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_extra: got %h want none", bus_b.Y);
        end else begin
          e = qb.pop_front();
          check("b_y", bus_b.Y, e.y);
          check("b_ovf", bus_b.OVF, e.o);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wcoef(logic [1:0] a, logic [15:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic setc(logic [15:0] c2, logic [15:0] c1, logic [15:0] c0);
    wcoef(2'd2, c2);
    wcoef(2'd1, c1);
    wcoef(2'd0, c0);
  endtask

  task automatic push(logic [23:0] ya, logic oa, logic [23:0] yb, logic ob);
    exp_t e;
    e.y = ya; e.o = oa; qa.push_back(e);
    e.y = yb; e.o = ob; qb.push_back(e);
  endtask

  task automatic send(logic [15:0] xv, logic [23:0] ya, logic oa,
                      logic [23:0] yb, logic ob);
    bit ok = 1'b0;
    x        = xv;
    in_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus_a.IN_READY) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) push(ya, oa, yb, ob);
    else begin
      tests++; fails++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (qa.size() == 0 && qb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending want 0", qa.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{16'h0100, 16'h0100, 16'h0000, 16'h0280,
              24'h0008C0, 1'b0, 24'h0008C0, 1'b0};
    vt[1] = '{16'h0100, 16'h0100, 16'h0000, 16'hFD00,
              24'h000600, 1'b0, 24'h000600, 1'b0};
    vt[2] = '{16'h0100, 16'h0100, 16'h0000, 16'hFF00,
              24'h000000, 1'b0, 24'h000000, 1'b0};
    vt[3] = '{16'h7F00, 16'h0000, 16'h0000, 16'h7F00,
              24'h7FFFFF, 1'b1, 24'h417F00, 1'b1};
    vt[4] = '{16'h0000, 16'h0001, 16'h0000, 16'h0080,
              24'h000001, 1'b0, 24'h000000, 1'b0};
    vt[5] = '{16'h0000, 16'h0001, 16'h0000, 16'hFF80,
              24'h000000, 1'b0, 24'hFFFFFF, 1'b0};
    vt[6] = '{16'h8000, 16'h0000, 16'h0000, 16'h7F00,
              24'h800000, 1'b1, 24'h7F8000, 1'b1};
    vt[7] = '{16'h0080, 16'hFF00, 16'h0300, 16'h0180,
              24'h0002A0, 1'b0, 24'h0002A0, 1'b0};
    vt[8] = '{16'h0001, 16'h0000, 16'h0000, 16'h0180,
              24'h000003, 1'b0, 24'h000001, 1'b0};

    en        = 1'b1;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    in_valid  = 1'b0;
    x         = '0;
    out_ready = 1'b1;
    rst       = 1'b1;
    tick();
    tick();
    check("rst_y", bus_a.Y, 24'h0);
    check("rst_ov", bus_a.OUT_VALID, 1'b0);
    check("rst_ovf", bus_a.OVF, 1'b0);
    check("rst_busy", bus_a.BUSY, 1'b0);
    rst = 1'b0;
    tick();
    check("rst_inready", bus_a.IN_READY, 1'b1);

    for (int i = 0; i < 9; i++) begin
      setc(vt[i].c2, vt[i].c1, vt[i].c0);
      wcoef(2'd3, 16'h7F7F);
      send(vt[i].x, vt[i].ya, vt[i].oa, vt[i].yb, vt[i].ob);
      drain();
    end

    // latency and backpressure, then a same-edge restart
    setc(16'h0100, 16'h0100, 16'h0000);
    out_ready = 1'b0;
    x         = 16'h0280;
    in_valid  = 1'b1;
    @(negedge clk);
    check("lat_inready", bus_a.IN_READY, 1'b1);
    push(24'h0008C0, 1'b0, 24'h0008C0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("lat_t0_busy", bus_a.BUSY, 1'b1);
    check("lat_t0_ov", bus_a.OUT_VALID, 1'b0);
    tick();
    check("lat_t1_ov", bus_a.OUT_VALID, 1'b0);
    tick();
    check("lat_t2_ov", bus_a.OUT_VALID, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ov", bus_a.OUT_VALID, 1'b1);
      check("bp_y", bus_a.Y, 24'h0008C0);
      check("bp_inready", bus_a.IN_READY, 1'b0);
    end
    out_ready = 1'b1;
    x         = 16'hFD00;
    in_valid  = 1'b1;
    @(negedge clk);
    check("b2b_inready", bus_a.IN_READY, 1'b1);
    push(24'h000600, 1'b0, 24'h000600, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_t0_ov", bus_a.OUT_VALID, 1'b0);
    check("b2b_t0_busy", bus_a.BUSY, 1'b1);
    tick();
    check("b2b_t1_ov", bus_a.OUT_VALID, 1'b0);
    tick();
    check("b2b_t2_ov", bus_a.OUT_VALID, 1'b1);
    drain();

    // coefficient write while calculating must not land
    send(16'h0280, 24'h0008C0, 1'b0, 24'h0008C0, 1'b0);
    wcoef(2'd0, 16'h0500);
    drain();

    // enable low for three cycles stretches latency
    send(16'hFD00, 24'h000600, 1'b0, 24'h000600, 1'b0);
    en = 1'b0;
    tick();
    tick();
    tick();
    check("en_busy", bus_a.BUSY, 1'b1);
    check("en_ov", bus_a.OUT_VALID, 1'b0);
    check("en_inready", bus_a.IN_READY, 1'b0);
    en = 1'b1;
    tick();
    check("en_t4_ov", bus_a.OUT_VALID, 1'b0);
    tick();
    check("en_t5_ov", bus_a.OUT_VALID, 1'b1);
    drain();

    // reset mid-calculation aborts and clears the bank
    send(16'h0280, 24'h0008C0, 1'b0, 24'h0008C0, 1'b0);
    rst = 1'b1;
    #1;
    check("abort_ov", bus_a.OUT_VALID, 1'b0);
    check("abort_y", bus_a.Y, 24'h0);
    check("abort_yb", bus_b.Y, 24'h0);
    check("abort_busy", bus_a.BUSY, 1'b0);
    qa.delete();
    qb.delete();
    tick();
    rst = 1'b0;
    tick();
    send(16'h0280, 24'h000000, 1'b0, 24'h000000, 1'b0);
    drain();

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
